// File: rtl/space_invaders_pkg.sv
// Shared types and screen constants for the space-invaders object movers.
package space_invaders_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    HIT
  } laser_state_t;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

endpackage

// File: rtl/blue_laser_controller_if.sv
// Control, scan and window signals between the game logic and the blue laser controller.
interface blue_laser_controller_if;
  import space_invaders_pkg::*;

  logic   startOfFrame;
  logic   fire;
  coord_t playerX;
  coord_t playerY;
  logic   collision;
  coord_t pixelX;
  coord_t pixelY;
  coord_t offsetX;
  coord_t offsetY;
  logic   InsideRectangle;
  logic   laserActive;
  coord_t topLeftX;
  coord_t topLeftY;

  modport master (
    output startOfFrame, fire, playerX, playerY, collision, pixelX, pixelY,
    input  offsetX, offsetY, InsideRectangle, laserActive, topLeftX, topLeftY
  );

  modport slave (
    input  startOfFrame, fire, playerX, playerY, collision, pixelX, pixelY,
    output offsetX, offsetY, InsideRectangle, laserActive, topLeftX, topLeftY
  );

endinterface

// File: rtl/square_object_window.sv
// Registered rectangle hit-test for a moving object; offsets feed a bitmap lookup.
module square_object_window
  import space_invaders_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  logic   clk,
  input  logic   resetN,
  input  coord_t pixelX,
  input  coord_t pixelY,
  input  coord_t topLeftX,
  input  coord_t topLeftY,
  input  logic   enable,
  output coord_t offsetX,
  output coord_t offsetY,
  output logic   InsideRectangle
);

  logic [11:0] rightEdge_d;
  logic [11:0] bottomEdge_d;
  logic        inside_d;
  coord_t      offsetX_q;
  coord_t      offsetY_q;
  logic        inside_q;

  // Edges kept one bit wider so objects near coordinate 2047 cannot wrap to a false hit.
  assign rightEdge_d  = {1'b0, topLeftX} + 12'(WIDTH);
  assign bottomEdge_d = {1'b0, topLeftY} + 12'(HEIGHT);

  assign inside_d = enable
                 && (pixelX >= topLeftX) && ({1'b0, pixelX} < rightEdge_d)
                 && (pixelY >= topLeftY) && ({1'b0, pixelY} < bottomEdge_d);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      offsetX_q <= '0;
      offsetY_q <= '0;
      inside_q  <= 1'b0;
    end else begin
      inside_q  <= inside_d;
      offsetX_q <= inside_d ? (pixelX - topLeftX) : '0;
      offsetY_q <= inside_d ? (pixelY - topLeftY) : '0;
    end
  end

  assign offsetX         = offsetX_q;
  assign offsetY         = offsetY_q;
  assign InsideRectangle = inside_q;

endmodule

// File: rtl/blue_laser_controller.sv
// Blue laser launch/flight/hit FSM with the laser's screen window for the bitmap stage.
module blue_laser_controller
  import space_invaders_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 64,
  parameter int SPEED_Y         = 4,
  parameter int TOP_LIMIT       = 0
) (
  input logic              clk,
  input logic              resetN,
  blue_laser_controller_if.slave laserIf
);

  laser_state_t state_q;
  coord_t       topLeftX_q;
  coord_t       topLeftY_q;
  coord_t       launchY_d;
  coord_t       movedY_d;
  logic         retire_d;
  logic         active_d;

  // The laser spawns just above the player, pinned to the top row for players near it.
  assign launchY_d = (laserIf.playerY < 11'(OBJECT_HEIGHT_Y)) ? '0
                   : laserIf.playerY - 11'(OBJECT_HEIGHT_Y);
  assign movedY_d  = topLeftY_q - 11'(SPEED_Y);
  assign retire_d  = ({1'b0, topLeftY_q} <= 12'(TOP_LIMIT + SPEED_Y));
  assign active_d  = (state_q != IDLE);

  // Collision takes priority over the frame move so a hit freezes the laser where it was struck.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      topLeftX_q <= '0;
      topLeftY_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          topLeftX_q <= laserIf.playerX;
          topLeftY_q <= launchY_d;
          if (laserIf.fire) state_q <= FLYING;
        end
        FLYING: begin
          if (laserIf.collision) begin
            state_q <= HIT;
          end else if (laserIf.startOfFrame) begin
            if (retire_d) state_q <= IDLE;
            else          topLeftY_q <= movedY_d;
          end
        end
        HIT: begin
          if (laserIf.startOfFrame) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign laserIf.laserActive = active_d;
  assign laserIf.topLeftX    = topLeftX_q;
  assign laserIf.topLeftY    = topLeftY_q;

  square_object_window #(
    .WIDTH  (OBJECT_WIDTH_X),
    .HEIGHT (OBJECT_HEIGHT_Y)
  ) window (
    .clk             (clk),
    .resetN          (resetN),
    .pixelX          (laserIf.pixelX),
    .pixelY          (laserIf.pixelY),
    .topLeftX        (topLeftX_q),
    .topLeftY        (topLeftY_q),
    .enable          (active_d),
    .offsetX         (laserIf.offsetX),
    .offsetY         (laserIf.offsetY),
    .InsideRectangle (laserIf.InsideRectangle)
  );

endmodule
